// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
// Byte lanes are ordered [0:3] with lane 0 carrying the most significant byte.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  typedef logic [7:0] byte_lane_t [0:3];

  localparam int unsigned MAX_D_STREAK_DEF = 4;
  localparam int unsigned TIMEOUT_CYC_DEF  = 64;

  function automatic logic [31:0] pack_lanes(input byte_lane_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter bundled into one interface.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  byte_lane_t  d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  byte_lane_t  d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  byte_lane_t  mem_wdata;
  logic        mem_ready;
  byte_lane_t  mem_rdata;
  logic        bus_err;

  modport slave (
    input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Cycle counter for outstanding memory accesses; expired flags the last
// allowed wait cycle so the arbiter can abort on that edge.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt_r;

  assign expired = (cnt_r == W'(TIMEOUT_CYC - 1));

  // Counts enabled cycles, saturating at the expiry value.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store:
// data has priority, fetch is guaranteed a slot after a streak of data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input logic               clk,
  input logic               rst_b,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state_r;
  arb_owner_t    owner_r;
  logic [SW-1:0] streak_r;
  logic          if_gnt_r;
  logic          d_gnt_r;
  logic          if_rvalid_r;
  logic          d_rvalid_r;
  logic [31:0]   if_rdata_r;
  logic [31:0]   d_rdata_r;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic          bus_err_r;

  logic          grant_s;
  logic          pick_if_s;
  logic          wd_en_s;
  logic          wd_clr_s;
  logic          wd_expired_s;

  // Fetch only wins against a pending data request once the streak is exhausted.
  assign pick_if_s = bus.if_req && (!bus.d_req || (streak_r == SW'(MAX_D_STREAK)));
  assign grant_s   = (state_r == IDLE) && !bus.halted && (bus.if_req || bus.d_req);
  assign wd_en_s   = (state_r == BUSY);
  assign wd_clr_s  = (state_r != BUSY);

  arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      owner_r     <= OWN_IF;
      streak_r    <= '0;
      if_gnt_r    <= 1'b0;
      d_gnt_r     <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      d_rdata_r   <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      bus_err_r   <= 1'b0;
    end else begin
      if_gnt_r    <= 1'b0;
      d_gnt_r     <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if (!bus.if_req) begin
        streak_r <= '0;
      end else begin
        streak_r <= streak_r;
      end
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r   <= BUSY;
            mem_req_r <= 1'b1;
            if (pick_if_s) begin
              owner_r     <= OWN_IF;
              if_gnt_r    <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= bus.if_addr;
              mem_wdata_r <= 32'h0000_0000;
              streak_r    <= '0;
            end else begin
              owner_r     <= OWN_D;
              d_gnt_r     <= 1'b1;
              mem_we_r    <= bus.d_we;
              mem_addr_r  <= bus.d_addr;
              mem_wdata_r <= pack_lanes(bus.d_wdata);
              streak_r    <= bus.if_req ? (streak_r + SW'(1)) : '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            state_r   <= RESP;
            mem_req_r <= 1'b0;
            if (owner_r == OWN_IF) begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= pack_lanes(bus.mem_rdata);
            end else begin
              d_rvalid_r <= 1'b1;
              if (!mem_we_r) begin
                d_rdata_r <= pack_lanes(bus.mem_rdata);
              end else begin
                d_rdata_r <= d_rdata_r;
              end
            end
          end else if (wd_expired_s) begin
            // Abandoned access still answers its owner so the core unstalls.
            state_r   <= RESP;
            mem_req_r <= 1'b0;
            bus_err_r <= 1'b1;
            if (owner_r == OWN_IF) begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= 32'h0000_0000;
            end else begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= 32'h0000_0000;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_r;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_gnt     = d_gnt_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.bus_err   = bus_err_r;

  for (genvar i = 0; i < 4; i++) begin : g_lanes
    assign bus.d_rdata[i]   = d_rdata_r[8*(3-i) +: 8];
    assign bus.mem_wdata[i] = mem_wdata_r[8*(3-i) +: 8];
  end

endmodule
